ahir2riffa_tx_packer: RTL and testbench

- Downstream TX stage between the AHIR output pipe and one RIFFA TX channel.
- Pulls words from the AHIR output pipe (read_req/read_ack) and buffers them in a first-word-fall-through FIFO.
- Once a full fixed-length transaction is buffered, issues one RIFFA TX transaction of TX_DATA_LEN dwords (LAST=1, OFF=0), streaming data under DATA_VALID/DATA_REN.
- Decouples AHIR output bursts from RIFFA TX grant latency.

---
 rtl/ahir2riffa_tx_packer_pkg.sv | 27 ++
 rtl/ahir2riffa_tx_packer_if.sv | 35 +++
 rtl/ahir2riffa_tx_packer_fifo.sv | 56 +++++
 rtl/ahir2riffa_tx_packer.sv | 85 ++++++++
 tb/tb_ahir2riffa_tx_packer.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ahir2riffa_tx_packer_pkg.sv
// Shared types and helpers for the AHIR-to-RIFFA TX packer.
// FSM encodings and derived-size functions.
package ahir2riffa_tx_packer_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_SEND = 2'd2;

  typedef logic [1:0] tx_state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? clog2(depth) : 1;
  endfunction

  function automatic int tx_words(input int len, input int width);
    return (len * 32) / width;
  endfunction

endpackage

// File: rtl/ahir2riffa_tx_packer_if.sv
// Pipe-side and RIFFA TX-side signal bundle.
// master = packer, slave = pipe source / RIFFA core.
interface ahir2riffa_tx_packer_if #(
  parameter int W = 32
);
  logic [W-1:0] pipe_read_data;
  logic         pipe_read_req;
  logic         pipe_read_ack;
  logic         CHNL_TX;
  logic         CHNL_TX_ACK;
  logic         CHNL_TX_LAST;
  logic [31:0]  CHNL_TX_LEN;
  logic [30:0]  CHNL_TX_OFF;
  logic [W-1:0] CHNL_TX_DATA;
  logic         CHNL_TX_DATA_VALID;
  logic         CHNL_TX_DATA_REN;

  modport master (
    input  pipe_read_data, pipe_read_ack,
    input  CHNL_TX_ACK, CHNL_TX_DATA_REN,
    output pipe_read_req, CHNL_TX,
    output CHNL_TX_LAST, CHNL_TX_LEN,
    output CHNL_TX_OFF, CHNL_TX_DATA,
    output CHNL_TX_DATA_VALID
  );

  modport slave (
    output pipe_read_data, pipe_read_ack,
    output CHNL_TX_ACK, CHNL_TX_DATA_REN,
    input  pipe_read_req, CHNL_TX,
    input  CHNL_TX_LAST, CHNL_TX_LEN,
    input  CHNL_TX_OFF, CHNL_TX_DATA,
    input  CHNL_TX_DATA_VALID
  );
endinterface

// File: rtl/ahir2riffa_tx_packer_fifo.sv
// First-word-fall-through synchronous FIFO.
// dout always shows the head word; DEPTH must be a power of two.
module sync_fwft_fifo
  import ahir2riffa_tx_packer_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic                    pop,
  input  logic [WIDTH-1:0]        din,
  output logic [WIDTH-1:0]        dout,
  output logic [ptr_w(DEPTH):0]   count,
  output logic                    full,
  output logic                    empty
);
  localparam int PW = ptr_w(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally at DEPTH; count tracks occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ahir2riffa_tx_packer.sv
// AHIR output pipe to RIFFA TX channel packer.
// Buffers a full transaction, then streams it as one RIFFA TX.
module ahir2riffa_tx_packer
  import ahir2riffa_tx_packer_pkg::*;
#(
  parameter int          C_PCI_DATA_WIDTH = 32,
  parameter logic [31:0] TX_DATA_LEN      = 32'd2,
  parameter int          FIFO_DEPTH       = 16
) (
  input  logic                       CLK,
  input  logic                       RST,
  ahir2riffa_tx_packer_if.master     bus,
  output logic [15:0]                tx_done_count
);
  localparam int TX_WORDS =
    tx_words(int'(TX_DATA_LEN), C_PCI_DATA_WIDTH);
  localparam int CW = ptr_w(FIFO_DEPTH) + 1;

  tx_state_t   state;
  logic [31:0] sent_cnt;
  logic [CW-1:0] count;
  logic        full;
  logic        empty;
  logic        push;
  logic        pop;
  logic        valid;

  assign bus.pipe_read_req = !RST && !full;
  assign push  = bus.pipe_read_req && bus.pipe_read_ack;
  assign valid = (state == ST_SEND) && !empty;
  assign pop   = valid && bus.CHNL_TX_DATA_REN;

  assign bus.CHNL_TX            = (state != ST_IDLE);
  assign bus.CHNL_TX_DATA_VALID = valid;
  assign bus.CHNL_TX_LAST       = 1'b1;
  assign bus.CHNL_TX_LEN        = TX_DATA_LEN;
  assign bus.CHNL_TX_OFF        = '0;

  sync_fwft_fifo #(
    .WIDTH (C_PCI_DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst   (RST),
    .push  (push),
    .pop   (pop),
    .din   (bus.pipe_read_data),
    .dout  (bus.CHNL_TX_DATA),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // Transaction FSM: wait for a full buffer, request, then stream.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state         <= ST_IDLE;
      sent_cnt      <= '0;
      tx_done_count <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (count >= CW'(TX_WORDS)) state <= ST_REQ;
        end
        ST_REQ: begin
          if (bus.CHNL_TX_ACK) begin
            state    <= ST_SEND;
            sent_cnt <= '0;
          end
        end
        ST_SEND: begin
          if (pop) begin
            sent_cnt <= sent_cnt + 32'd1;
            if (sent_cnt == 32'(TX_WORDS - 1)) begin
              state         <= ST_IDLE;
              tx_done_count <= tx_done_count + 16'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ahir2riffa_tx_packer.sv
// Directed testbench for ahir2riffa_tx_packer.
// Two instances: 32-bit/LEN 2 and 64-bit/LEN 4.
module tb_ahir2riffa_tx_packer;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  ahir2riffa_tx_packer_if #(.W(32)) a_if ();
  ahir2riffa_tx_packer_if #(.W(64)) b_if ();

  logic [15:0] done_a;
  logic [15:0] done_b;

  ahir2riffa_tx_packer #(
    .C_PCI_DATA_WIDTH (32),
    .TX_DATA_LEN      (32'd2),
    .FIFO_DEPTH       (16)
  ) dut_a (
    .CLK           (CLK),
    .RST           (RST),
    .bus           (a_if),
    .tx_done_count (done_a)
  );

  ahir2riffa_tx_packer #(
    .C_PCI_DATA_WIDTH (64),
    .TX_DATA_LEN      (32'd4),
    .FIFO_DEPTH       (16)
  ) dut_b (
    .CLK           (CLK),
    .RST           (RST),
    .bus           (b_if),
    .tx_done_count (done_b)
  );

  int checks = 0;
  int errors = 0;
  logic [63:0] qa[$];
  logic [63:0] qb[$];

  // Record every beat the RIFFA side accepts.
  always @(posedge CLK) begin
    if (!RST && a_if.CHNL_TX_DATA_VALID && a_if.CHNL_TX_DATA_REN)
      qa.push_back(64'(a_if.CHNL_TX_DATA));
    if (!RST && b_if.CHNL_TX_DATA_VALID && b_if.CHNL_TX_DATA_REN)
      qb.push_back(b_if.CHNL_TX_DATA);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic feed_a(input logic [31:0] w0, input logic [31:0] w1);
    a_if.pipe_read_ack  = 1'b1;
    a_if.pipe_read_data = w0;
    tick();
    a_if.pipe_read_data = w1;
    tick();
    a_if.pipe_read_ack = 1'b0;
  endtask

  task automatic wait_tx_a(input string tag);
    int n;
    n = 0;
    #1;
    while (!a_if.CHNL_TX && n < 20) begin
      tick();
      n++;
    end
    chk(tag, 64'(a_if.CHNL_TX), 64'd1);
  endtask

  initial begin
    int acc;
    int pushed;
    int n;
    int bad;
    logic stable;
    logic [15:0] d0;

    a_if.pipe_read_data   = '0;
    a_if.pipe_read_ack    = 1'b0;
    a_if.CHNL_TX_ACK      = 1'b0;
    a_if.CHNL_TX_DATA_REN = 1'b0;
    b_if.pipe_read_data   = '0;
    b_if.pipe_read_ack    = 1'b0;
    b_if.CHNL_TX_ACK      = 1'b0;
    b_if.CHNL_TX_DATA_REN = 1'b0;

    tick();
    tick();
    chk("rst_tx", 64'(a_if.CHNL_TX), 64'd0);
    chk("rst_valid", 64'(a_if.CHNL_TX_DATA_VALID), 64'd0);
    chk("rst_req", 64'(a_if.pipe_read_req), 64'd0);
    chk("rst_done", 64'(done_a), 64'd0);
    RST = 1'b0;
    #1;
    chk("req_after_rst", 64'(a_if.pipe_read_req), 64'd1);
    chk("len", 64'(a_if.CHNL_TX_LEN), 64'd2);
    chk("last", 64'(a_if.CHNL_TX_LAST), 64'd1);
    chk("off", 64'(a_if.CHNL_TX_OFF), 64'd0);

    // Basic transaction
    tick();
    feed_a(32'h11, 32'h22);
    #1;
    chk("basic_tx_latency", 64'(a_if.CHNL_TX), 64'd0);
    tick();
    #1;
    chk("basic_tx_high", 64'(a_if.CHNL_TX), 64'd1);
    chk("basic_req_novalid", 64'(a_if.CHNL_TX_DATA_VALID), 64'd0);
    tick();
    tick();
    a_if.CHNL_TX_ACK      = 1'b1;
    a_if.CHNL_TX_DATA_REN = 1'b1;
    tick();
    a_if.CHNL_TX_ACK = 1'b0;
    #1;
    chk("basic_v0", 64'(a_if.CHNL_TX_DATA_VALID), 64'd1);
    chk("basic_d0", 64'(a_if.CHNL_TX_DATA), 64'h11);
    tick();
    #1;
    chk("basic_v1", 64'(a_if.CHNL_TX_DATA_VALID), 64'd1);
    chk("basic_d1", 64'(a_if.CHNL_TX_DATA), 64'h22);
    tick();
    a_if.CHNL_TX_DATA_REN = 1'b0;
    #1;
    chk("basic_tx_drop", 64'(a_if.CHNL_TX), 64'd0);
    chk("basic_valid_drop", 64'(a_if.CHNL_TX_DATA_VALID), 64'd0);
    chk("basic_done", 64'(done_a), 64'd1);
    chk("basic_beats", 64'(qa.size()), 64'd2);
    chk("basic_q0", qa[0], 64'h11);
    chk("basic_q1", qa[1], 64'h22);

    // REN stall mid-SEND
    qa.delete();
    tick();
    feed_a(32'h33, 32'h44);
    wait_tx_a("stall_tx");
    a_if.CHNL_TX_ACK = 1'b1;
    tick();
    a_if.CHNL_TX_ACK      = 1'b0;
    a_if.CHNL_TX_DATA_REN = 1'b1;
    #1;
    chk("stall_d0", 64'(a_if.CHNL_TX_DATA), 64'h33);
    tick();
    a_if.CHNL_TX_DATA_REN = 1'b0;
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (!(a_if.CHNL_TX_DATA_VALID === 1'b1 &&
            a_if.CHNL_TX_DATA === 32'h44))
        stable = 1'b0;
      tick();
    end
    chk("stall_hold", 64'(stable), 64'd1);
    chk("stall_sent_cnt", 64'(dut_a.sent_cnt), 64'd1);
    a_if.CHNL_TX_DATA_REN = 1'b1;
    tick();
    a_if.CHNL_TX_DATA_REN = 1'b0;
    #1;
    chk("stall_tx_drop", 64'(a_if.CHNL_TX), 64'd0);
    chk("stall_done", 64'(done_a), 64'd2);
    chk("stall_beats", 64'(qa.size()), 64'd2);
    chk("stall_q0", qa[0], 64'h33);
    chk("stall_q1", qa[1], 64'h44);

    // Full FIFO with ACK withheld
    qa.delete();
    tick();
    acc = 0;
    a_if.pipe_read_ack = 1'b1;
    for (int i = 0; i < 20; i++) begin
      a_if.pipe_read_data = 32'h100 + 32'(acc);
      #1;
      if (a_if.pipe_read_req) acc++;
      tick();
    end
    a_if.pipe_read_ack = 1'b0;
    #1;
    chk("full_accepted", 64'(acc), 64'd16);
    chk("full_req_low", 64'(a_if.pipe_read_req), 64'd0);
    chk("full_tx_waiting", 64'(a_if.CHNL_TX), 64'd1);
    a_if.CHNL_TX_ACK = 1'b1;
    tick();
    a_if.CHNL_TX_ACK      = 1'b0;
    a_if.CHNL_TX_DATA_REN = 1'b1;
    #1;
    chk("full_req_still_low", 64'(a_if.pipe_read_req), 64'd0);
    tick();
    a_if.CHNL_TX_DATA_REN = 1'b0;
    #1;
    chk("full_req_back", 64'(a_if.pipe_read_req), 64'd1);
    a_if.CHNL_TX_ACK      = 1'b1;
    a_if.CHNL_TX_DATA_REN = 1'b1;
    for (int i = 0; i < 60; i++) tick();
    a_if.CHNL_TX_ACK      = 1'b0;
    a_if.CHNL_TX_DATA_REN = 1'b0;
    chk("full_beats", 64'(qa.size()), 64'd16);
    bad = 0;
    for (int i = 0; i < qa.size(); i++)
      if (qa[i] !== 64'h100 + 64'(i)) bad++;
    chk("full_order", 64'(bad), 64'd0);
    chk("full_done", 64'(done_a), 64'd10);

    // Streaming with simultaneous push/pop across pointer wrap
    qa.delete();
    tick();
    d0 = done_a;
    pushed = 0;
    n = 0;
    a_if.CHNL_TX_ACK      = 1'b1;
    a_if.CHNL_TX_DATA_REN = 1'b1;
    while (qa.size() < 40 && n < 400) begin
      if (pushed < 40) begin
        a_if.pipe_read_ack  = 1'b1;
        a_if.pipe_read_data = 32'h200 + 32'(pushed);
      end else begin
        a_if.pipe_read_ack = 1'b0;
      end
      #1;
      if (a_if.pipe_read_ack && a_if.pipe_read_req) pushed++;
      tick();
      n++;
    end
    a_if.pipe_read_ack    = 1'b0;
    tick();
    tick();
    a_if.CHNL_TX_ACK      = 1'b0;
    a_if.CHNL_TX_DATA_REN = 1'b0;
    chk("wrap_beats", 64'(qa.size()), 64'd40);
    bad = 0;
    for (int i = 0; i < qa.size(); i++)
      if (qa[i] !== 64'h200 + 64'(i)) bad++;
    chk("wrap_order", 64'(bad), 64'd0);
    chk("wrap_tx_count", 64'(done_a - d0), 64'd20);

    // Reset mid-SEND
    qa.delete();
    tick();
    feed_a(32'hA, 32'hB);
    wait_tx_a("rstsend_tx");
    a_if.CHNL_TX_ACK = 1'b1;
    tick();
    a_if.CHNL_TX_ACK      = 1'b0;
    a_if.CHNL_TX_DATA_REN = 1'b1;
    #1;
    chk("rstsend_d0", 64'(a_if.CHNL_TX_DATA), 64'hA);
    tick();
    a_if.CHNL_TX_DATA_REN = 1'b0;
    RST = 1'b1;
    tick();
    RST = 1'b0;
    #1;
    chk("rstsend_tx_low", 64'(a_if.CHNL_TX), 64'd0);
    chk("rstsend_valid_low", 64'(a_if.CHNL_TX_DATA_VALID), 64'd0);
    chk("rstsend_count", 64'(dut_a.count), 64'd0);
    chk("rstsend_done", 64'(done_a), 64'd0);
    a_if.CHNL_TX_ACK      = 1'b1;
    a_if.CHNL_TX_DATA_REN = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    a_if.CHNL_TX_ACK      = 1'b0;
    a_if.CHNL_TX_DATA_REN = 1'b0;
    chk("rstsend_idle", 64'(a_if.CHNL_TX), 64'd0);
    chk("rstsend_beats", 64'(qa.size()), 64'd1);
    chk("rstsend_q0", qa[0], 64'hA);

    // 64-bit instance, TX_DATA_LEN = 4
    qb.delete();
    chk("w64_len", 64'(b_if.CHNL_TX_LEN), 64'd4);
    b_if.pipe_read_ack  = 1'b1;
    b_if.pipe_read_data = 64'h1111_2222_3333_4444;
    tick();
    b_if.pipe_read_data = 64'h5555_6666_7777_8888;
    tick();
    b_if.pipe_read_ack = 1'b0;
    n = 0;
    #1;
    while (!b_if.CHNL_TX && n < 20) begin
      tick();
      n++;
    end
    chk("w64_tx", 64'(b_if.CHNL_TX), 64'd1);
    b_if.CHNL_TX_ACK      = 1'b1;
    b_if.CHNL_TX_DATA_REN = 1'b1;
    tick();
    b_if.CHNL_TX_ACK = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    b_if.CHNL_TX_DATA_REN = 1'b0;
    chk("w64_beats", 64'(qb.size()), 64'd2);
    chk("w64_q0", qb[0], 64'h1111_2222_3333_4444);
    chk("w64_q1", qb[1], 64'h5555_6666_7777_8888);
    chk("w64_done", 64'(done_b), 64'd1);
    chk("w64_tx_low", 64'(b_if.CHNL_TX), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
